pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the mini-MIPS fetch stage. It replaces the plain load-next-PC register with on-chip next-PC selection. Selection covers sequential increment, stall hold, branch/jump redirect, call/return through a circular return-address stack (RAS), and exception entry/return with a saved EPC. Fetch reads `pc`; decode/execute drive the redirect, call/return and exception controls.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the mini-MIPS fetch stage: next-PC selection
// with stall, redirect, call/return through a circular RAS, and exception entry/return.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_target,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         exc,
    input  logic                         eret,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_plus,
    output logic [XLEN-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_n;
    logic [XLEN-1:0]  pc_n;
    logic [XLEN-1:0]  epc_n;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_n;
    logic             unf_n;
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    logic             ras_empty;
    logic             ras_full;

    assign pc_plus   = pc + XLEN'(INSTR_BYTES);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

    // Next-PC / RAS selection; exc and eret bypass stall.
    always_comb begin
        pc_n      = pc;
        epc_n     = epc;
        top_n     = top;
        cnt_n     = ras_count;
        ovf_n     = ras_overflow;
        unf_n     = ras_underflow;
        ras_we    = 1'b0;
        ras_waddr = top;
        if (exc) begin
            pc_n  = EXC_VECTOR;
            epc_n = pc;
        end else if (eret) begin
            pc_n = epc;
        end else if (!stall) begin
            if (redirect_valid && ret && !call) begin
                if (!ras_empty) begin
                    pc_n  = ras_mem[top];
                    top_n = top - PTR_W'(1);
                    cnt_n = ras_count - CNT_W'(1);
                end else begin
                    pc_n  = redirect_target;
                    unf_n = 1'b1;
                end
            end else if (redirect_valid && call && !ret) begin
                pc_n      = redirect_target;
                ras_we    = 1'b1;
                ras_waddr = top + PTR_W'(1);
                top_n     = top + PTR_W'(1);
                if (ras_full) begin
                    ovf_n = 1'b1;
                end else begin
                    cnt_n = ras_count + CNT_W'(1);
                end
            end else if (redirect_valid && call && ret) begin
                // Swap: return through the top entry, then replace it in place.
                ras_we = 1'b1;
                if (!ras_empty) begin
                    pc_n = ras_mem[top];
                end else begin
                    pc_n  = redirect_target;
                    unf_n = 1'b1;
                    cnt_n = CNT_W'(1);
                end
            end else if (redirect_valid) begin
                pc_n = redirect_target;
            end else begin
                pc_n = pc_plus;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= RESET_VECTOR;
            epc           <= '0;
            top           <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_n;
            epc           <= epc_n;
            top           <= top_n;
            ras_count     <= cnt_n;
            ras_overflow  <= ovf_n;
            ras_underflow <= unf_n;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem[ras_waddr] <= pc_plus;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven scenarios with a queue of
// expected post-edge states compared one cycle after each stimulus.
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        call;
    logic        ret;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] epc;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] EXC   = 6'b100000;
    localparam logic [5:0] ERET  = 6'b010000;
    localparam logic [5:0] STALL = 6'b001000;
    localparam logic [5:0] RV    = 6'b000100;
    localparam logic [5:0] CALL  = 6'b000010;
    localparam logic [5:0] RET   = 6'b000001;
    localparam logic [5:0] IDLE  = 6'b000000;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } row_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp;
        logic [31:0] epc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } obs_t;

    obs_t exp_q[$];
    row_t rows[$];

    pc_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .exc             (exc),
        .eret            (eret),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .epc             (epc),
        .ras_count       (ras_count),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic row_t R(input logic [5:0] c, input logic [31:0] t, input logic [31:0] p,
                               input logic [31:0] e, input logic [2:0] n, input logic o, input logic u);
        return {c, t, p, e, n, o, u};
    endfunction

    function automatic obs_t observe();
        return {pc, pc_plus, epc, ras_count, ras_overflow, ras_underflow};
    endfunction

    function automatic obs_t expect_of(input logic [31:0] p, input logic [31:0] e,
                                       input logic [2:0] n, input logic o, input logic u);
        return {p, p + 32'd4, e, n, o, u};
    endfunction

    task automatic set_idle();
        {exc, eret, stall, redirect_valid, call, ret} = IDLE;
        redirect_target = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Drive one cycle of stimulus, queue its expected result, sample after the edge.
    task automatic apply(input row_t r);
        {exc, eret, stall, redirect_valid, call, ret} = r.ctl;
        redirect_target = r.tgt;
        exp_q.push_back(expect_of(r.pc, r.epc, r.cnt, r.ovf, r.unf));
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        obs_t got, want;
        set_idle();
        reset_n = 1'b0;
        #1;
        exp_q.push_back(expect_of(32'h0, 32'h0, 3'd0, 1'b0, 1'b0));
        got = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset got=%h want=%h", got, want);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rows = {};
        for (int i = 1; i <= 4; i++) rows.push_back(R(IDLE, 32'h0, 32'(4 * i), 32'h0, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_seq[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(IDLE, 32'h0,         32'h0000_0000, 32'h0, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wrap[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV,       32'h10,  32'h10,  32'h0, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL, 32'h100, 32'h100, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(RV | RET,  32'hDEAD, 32'h14, 32'h0, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(RV | RET,  32'h200, 32'h200, 32'h0, 3'd0, 1'b0, 1'b1));
        rows.push_back(R(IDLE,     32'h0,   32'h204, 32'h0, 3'd0, 1'b0, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL call_ret[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_stall();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV | CALL, 32'h100, 32'h100, 32'h0, 3'd1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) rows.push_back(R(STALL | RV | CALL, 32'h300, 32'h100, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(STALL | RV | RET, 32'h300, 32'h100, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(IDLE, 32'h0, 32'h104, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(RV | RET, 32'h999, 32'h4, 32'h0, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stall[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_overflow();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV | CALL, 32'h100, 32'h100, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL, 32'h200, 32'h200, 32'h0, 3'd2, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL, 32'h300, 32'h300, 32'h0, 3'd3, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL, 32'h400, 32'h400, 32'h0, 3'd4, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL, 32'h500, 32'h500, 32'h0, 3'd4, 1'b1, 1'b0));
        rows.push_back(R(RV | RET,  32'h999, 32'h404, 32'h0, 3'd3, 1'b1, 1'b0));
        rows.push_back(R(RV | RET,  32'h999, 32'h304, 32'h0, 3'd2, 1'b1, 1'b0));
        rows.push_back(R(RV | RET,  32'h999, 32'h204, 32'h0, 3'd1, 1'b1, 1'b0));
        rows.push_back(R(RV | RET,  32'h999, 32'h104, 32'h0, 3'd0, 1'b1, 1'b0));
        rows.push_back(R(RV | RET,  32'h600, 32'h600, 32'h0, 3'd0, 1'b1, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL overflow[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_swap();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV | CALL,       32'h100, 32'h100, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL | RET, 32'h900, 32'h004, 32'h0, 3'd1, 1'b0, 1'b0));
        rows.push_back(R(RV | RET,        32'h999, 32'h104, 32'h0, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(RV | CALL | RET, 32'h700, 32'h700, 32'h0, 3'd1, 1'b0, 1'b1));
        rows.push_back(R(RV | RET,        32'h999, 32'h108, 32'h0, 3'd0, 1'b0, 1'b1));
        rows.push_back(R(CALL,            32'h555, 32'h10C, 32'h0, 3'd0, 1'b0, 1'b1));
        rows.push_back(R(RET,             32'h555, 32'h110, 32'h0, 3'd0, 1'b0, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL swap[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_exception();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV,               32'h40,  32'h40, 32'h0,  3'd0, 1'b0, 1'b0));
        rows.push_back(R(EXC | STALL | RV, 32'h999, 32'h80, 32'h40, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(IDLE,             32'h0,   32'h84, 32'h40, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(IDLE,             32'h0,   32'h88, 32'h40, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(ERET,             32'h0,   32'h40, 32'h40, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(EXC | ERET,       32'h0,   32'h80, 32'h40, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(ERET | STALL,     32'h0,   32'h40, 32'h40, 3'd0, 1'b0, 1'b0));
        rows.push_back(R(EXC | RV | CALL,  32'h300, 32'h80, 32'h40, 3'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL exception[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        do_reset();
        rows = {};
        rows.push_back(R(RV | RET,  32'h200, 32'h200, 32'h0, 3'd0, 1'b0, 1'b1));
        rows.push_back(R(RV | CALL, 32'h300, 32'h300, 32'h0, 3'd1, 1'b0, 1'b1));
        rows.push_back(R(EXC,       32'h0,   32'h80,  32'h300, 3'd1, 1'b0, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            got = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL async_pre[%0d] got=%h want=%h", i, got, want);
            end
        end
        // Mid-cycle reset with a call in flight; values must drop before any edge.
        {redirect_valid, call} = 2'b11;
        redirect_target = 32'h500;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(expect_of(32'h0, 32'h0, 3'd0, 1'b0, 1'b0));
        got = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", got, want);
        end
        set_idle();
        @(negedge clk);
        reset_n = 1'b1;
        apply(R(IDLE, 32'h0, 32'h4, 32'h0, 3'd0, 1'b0, 1'b0));
        got = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_release got=%h want=%h", got, want);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        test_reset();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_swap();
        test_exception();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
